// File: rtl/fetch_decode_pkg.sv
// Shared constants and types for the fetch/decode stage: RV32I opcodes,
// immediate formats, control states and the NOP word loaded into the IR on reset.
package fetch_decode_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DROP
    } state_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD, JALR: return FMT_I;
            STORE:              return FMT_S;
            BRANCH:             return FMT_B;
            LUI, AUIPC:         return FMT_U;
            JAL:                return FMT_J;
            default:            return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fetch_decode_unit_imm_gen.sv
// Combinational RV32I immediate generator: selects the format from the opcode
// and produces the sign-extended 32-bit immediate (0 for formats without one).
module imm_gen
    import fetch_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm32
);

    always_comb begin
        // NOTE: assigning a default first keeps this block free of inferred latches.
        imm32 = '0;
        case (imm_fmt_of(instr[6:0]))
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'h000};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: PC, instruction-memory handshake with multi-cycle latency,
// IR decode and branch redirect with in-flight kill. FETCH_PERF_CNT_EN adds counters.
module fetch_decode_unit
    import fetch_decode_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [31:0]       dec_instr,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [31:0]       imm32
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_killed
`endif
);

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] redirect_target;
    logic              req_fire;

    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    // Reset gates the request so nothing is issued while rst_n is low.
    assign imem_req_valid  = rst_n && (state == S_REQ) && fetch_en && !redirect_valid;
    assign imem_req_addr   = pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign dec_instr = ir;
    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign funct3    = ir[14:12];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign funct7    = ir[31:25];

    imm_gen u_imm_gen (
        .instr (ir),
        .imm32 (imm32)
    );

    // NOTE: reset is tested inside the clocked block, making it synchronous; all
    // state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            ir        <= NOP;
            dec_pc    <= '0;
            dec_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end else if (req_fire) begin
                        req_pc <= pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        // A response in the same cycle is dropped; otherwise it is still owed.
                        state <= imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        ir        <= imem_rsp_data;
                        dec_pc    <= req_pc;
                        pc        <= req_pc + ADDR_W'(4);
                        dec_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        pc        <= redirect_target;
                        dec_valid <= 1'b0;
                        state     <= S_REQ;
                    end else if (dec_ready) begin
                        dec_valid <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
        end else begin
            if (state == S_OUT && dec_ready && !redirect_valid) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == S_WAIT && redirect_valid && imem_rsp_valid) ||
                (state == S_DROP && imem_rsp_valid) ||
                (state == S_OUT && redirect_valid)) begin
                perf_killed <= perf_killed + 32'd1;
            end
        end
    end
`endif

endmodule
